// File: rtl/caf_pkg.sv
// Shared definitions for the complex-sample front end: window state encoding
// and a helper that sizes counters.
package caf_pkg;

  typedef enum logic [0:0] {
    StFill,
    StStream
  } win_state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpx_window_shift.sv
// Complex shift register: element 0 is the oldest sample, length-1 the newest.
// Exposes the post-shift contents combinationally so the owner can capture a
// window on the same edge the shift happens.
module cpx_window_shift #(
  parameter int unsigned i_bits = 12,
  parameter int unsigned q_bits = 12,
  parameter int unsigned length = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_shift_en,
  input  logic [i_bits-1:0]          i_xi,
  input  logic [q_bits-1:0]          i_xq,
  output logic [i_bits*length-1:0]   o_next_wi,
  output logic [q_bits*length-1:0]   o_next_wq
);

  logic [i_bits*length-1:0] r_si;
  logic [q_bits*length-1:0] r_sq;

  // Dropping the low element and appending at the top is the k <- k+1 shift.
  assign o_next_wi = {i_xi, r_si[i_bits*length-1:i_bits]};
  assign o_next_wq = {i_xq, r_sq[q_bits*length-1:q_bits]};

  // Storage update on each accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_si <= '0;
      r_sq <= '0;
    end else if (i_shift_en) begin
      r_si <= o_next_wi;
      r_sq <= o_next_wq;
    end
  end

endmodule

// File: rtl/cpx_window.sv
// Sliding window over a complex sample stream. Emits a full window after
// `length` samples, then every `stride` samples, with a registered
// valid/ready handshake towards the consumer.
module cpx_window
  import caf_pkg::*;
#(
  parameter int unsigned i_bits = 12,
  parameter int unsigned q_bits = 12,
  parameter int unsigned length = 5,
  parameter int unsigned stride = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        m_axis_data_tvalid,
  output logic                        s_axis_data_tready,
  input  logic signed [i_bits-1:0]    xi,
  input  logic signed [q_bits-1:0]    xq,
  input  logic                        m_axis_window_tready,
  output logic                        s_axis_tvalid,
  output logic [i_bits*length-1:0]    wi,
  output logic [q_bits*length-1:0]    wq
);

  localparam int unsigned FillW = cnt_width(length);
  localparam int unsigned HopW  = cnt_width(stride);

  win_state_e              r_state, w_state_next;
  logic [FillW-1:0]        r_fill, w_fill_next;
  logic [HopW-1:0]         r_hop, w_hop_next;
  logic                    w_accept, w_emit;
  logic                    r_tvalid;
  logic [i_bits*length-1:0] r_wi, w_next_wi;
  logic [q_bits*length-1:0] r_wq, w_next_wq;

  // A pending window blocks intake until the consumer takes it.
  assign s_axis_data_tready = !reset && !clear && (!r_tvalid || m_axis_window_tready);
  assign w_accept           = m_axis_data_tvalid && s_axis_data_tready;

  cpx_window_shift #(
    .i_bits (i_bits),
    .q_bits (q_bits),
    .length (length)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .i_shift_en (w_accept),
    .i_xi       (xi),
    .i_xq       (xq),
    .o_next_wi  (w_next_wi),
    .o_next_wq  (w_next_wq)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFill;
      r_fill  <= '0;
      r_hop   <= '0;
    end else begin
      r_state <= w_state_next;
      r_fill  <= w_fill_next;
      r_hop   <= w_hop_next;
    end
  end

  // Next-state and counter advance on each accepted sample.
  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    w_hop_next   = r_hop;
    if (clear) begin
      w_state_next = StFill;
      w_fill_next  = '0;
      w_hop_next   = '0;
    end else if (w_accept) begin
      unique case (r_state)
        StFill: begin
          if (r_fill == FillW'(length - 1)) begin
            w_state_next = StStream;
            w_fill_next  = '0;
            w_hop_next   = '0;
          end else begin
            w_fill_next = r_fill + FillW'(1);
          end
        end
        StStream: begin
          if (r_hop == HopW'(stride - 1)) w_hop_next = '0;
          else                            w_hop_next = r_hop + HopW'(1);
        end
        default: w_state_next = StFill;
      endcase
    end
  end

  // Emit decision: the accept that completes the fill or a stride hop.
  always_comb begin
    w_emit = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        StFill:   w_emit = (r_fill == FillW'(length - 1));
        StStream: w_emit = (r_hop == HopW'(stride - 1));
        default:  w_emit = 1'b0;
      endcase
    end
  end

  // Window output register; emit can only coincide with a free or draining slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid <= 1'b0;
      r_wi     <= '0;
      r_wq     <= '0;
    end else if (clear) begin
      r_tvalid <= 1'b0;
    end else if (w_emit) begin
      r_tvalid <= 1'b1;
      r_wi     <= w_next_wi;
      r_wq     <= w_next_wq;
    end else if (r_tvalid && m_axis_window_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign s_axis_tvalid = r_tvalid;
  assign wi            = r_wi;
  assign wq            = r_wq;

endmodule

// File: tb/tb_cpx_window.sv
// Bench for cpx_window: two instances (stride 1 and stride 2) share one input
// stream; a sample-history model predicts each instance's outputs.
module tb_cpx_window;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        reset, clear, vin, wrdy;
  logic [11:0] xi, xq;
  logic        tr_a, tv_a, tr_b, tv_b;
  logic [59:0] wi_a, wq_a, wi_b, wq_b;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  cpx_window #(.i_bits(12), .q_bits(12), .length(L), .stride(1)) dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .m_axis_data_tvalid(vin), .s_axis_data_tready(tr_a),
    .xi(xi), .xq(xq), .m_axis_window_tready(wrdy),
    .s_axis_tvalid(tv_a), .wi(wi_a), .wq(wq_a)
  );

  cpx_window #(.i_bits(12), .q_bits(12), .length(L), .stride(2)) dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .m_axis_data_tvalid(vin), .s_axis_data_tready(tr_b),
    .xi(xi), .xq(xq), .m_axis_window_tready(wrdy),
    .s_axis_tvalid(tv_b), .wi(wi_b), .wq(wq_b)
  );

  // ---------------- model: history of accepted samples since restart
  logic [11:0] hi [2][256];
  logic [11:0] hq [2][256];
  int          cnt  [2];
  logic        mval [2];
  logic [59:0] mwi  [2];
  logic [59:0] mwq  [2];
  logic        m_tr, m_acc;
  int          m_s;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; mval[k] = 1'b0; mwi[k] = '0; mwq[k] = '0;
    end
  end

  function automatic logic exp_tr(input int k);
    return !reset && !clear && (!mval[k] || wrdy);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_s  = (k == 0) ? 1 : 2;
      m_tr = exp_tr(k);
      if (reset) begin
        mval[k] = 1'b0; cnt[k] = 0; mwi[k] = '0; mwq[k] = '0;
      end else if (clear) begin
        mval[k] = 1'b0; cnt[k] = 0;
      end else begin
        m_acc = vin && m_tr;
        if (mval[k] && wrdy) mval[k] = 1'b0;
        if (m_acc && cnt[k] < 256) begin
          hi[k][cnt[k]] = xi;
          hq[k][cnt[k]] = xq;
          cnt[k]++;
          if (cnt[k] >= L && ((cnt[k] - L) % m_s) == 0) begin
            mval[k] = 1'b1;
            for (int j = 0; j < L; j++) begin
              mwi[k][12*j +: 12] = hi[k][cnt[k]-L+j];
              mwq[k][12*j +: 12] = hq[k][cnt[k]-L+j];
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [59:0] got, input logic [59:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk1("tready_a", tr_a, exp_tr(0));
      chk1("tvalid_a", tv_a, mval[0]);
      if (mval[0]) begin
        chk("wi_a", wi_a, mwi[0]);
        chk("wq_a", wq_a, mwq[0]);
      end
      chk1("tready_b", tr_b, exp_tr(1));
      chk1("tvalid_b", tv_b, mval[1]);
      if (mval[1]) begin
        chk("wi_b", wi_b, mwi[1]);
        chk("wq_b", wq_b, mwq[1]);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations
  function automatic logic [59:0] pk(input int e0, input int e1, input int e2,
                                     input int e3, input int e4);
    return {12'(e4), 12'(e3), 12'(e2), 12'(e1), 12'(e0)};
  endfunction

  task automatic step(input logic v, input int a, input logic r, input logic c,
                      input logic w);
    vin = v; xi = 12'(a); xq = 12'(-a); reset = r; clear = c; wrdy = w;
    @(posedge clk);
    #2;
  endtask

  initial begin
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    started = 1'b1;
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk1("rst_tvalid", tv_a, 1'b0);
    chk1("rst_tready", tr_a, 1'b0);
    chk("rst_wi", wi_a, 60'd0);
    chk("rst_wq", wq_a, 60'd0);

    // Fill and slide
    for (int a = 1; a <= 5; a++) begin
      step(1'b1, a, 1'b0, 1'b0, 1'b1);
      if (a == 4) chk1("fill_early", tv_a, 1'b0);
    end
    chk1("fill_tvalid", tv_a, 1'b1);
    chk("fill_wi", wi_a, pk(1, 2, 3, 4, 5));
    chk("fill_wq", wq_a, pk(-1, -2, -3, -4, -5));
    chk("strd_w1", wi_b, pk(1, 2, 3, 4, 5));
    step(1'b1, 6, 1'b0, 1'b0, 1'b1);
    chk("slide_w6", wi_a, pk(2, 3, 4, 5, 6));
    chk1("strd_gap6", tv_b, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0, 1'b1);
    chk("slide_w7", wi_a, pk(3, 4, 5, 6, 7));
    chk("strd_w7", wi_b, pk(3, 4, 5, 6, 7));
    step(1'b1, 8, 1'b0, 1'b0, 1'b1);
    chk1("strd_gap8", tv_b, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0, 1'b1);
    chk("strd_w9", wi_b, pk(5, 6, 7, 8, 9));

    // Backpressure
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk1("clr_tvalid", tv_a, 1'b0);
    for (int a = 1; a <= 5; a++) step(1'b1, a, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 6, 1'b0, 1'b0, 1'b0);
      chk1("bp_tready", tr_a, 1'b0);
      chk1("bp_tvalid", tv_a, 1'b1);
      chk("bp_hold", wi_a, pk(1, 2, 3, 4, 5));
    end
    step(1'b1, 6, 1'b0, 1'b0, 1'b1);
    chk("bp_release", wi_a, pk(2, 3, 4, 5, 6));
    step(1'b1, 7, 1'b0, 1'b0, 1'b1);

    // Clear mid-stream
    step(1'b1, 8, 1'b0, 1'b1, 1'b1);
    chk1("clr_mid", tv_a, 1'b0);
    for (int a = 20; a <= 24; a++) begin
      step(1'b1, a, 1'b0, 1'b0, 1'b1);
      if (a == 23) chk1("clr_refill_early", tv_a, 1'b0);
    end
    chk("clr_refill", wi_a, pk(20, 21, 22, 23, 24));
    chk("clr_refill_q", wq_a, pk(-20, -21, -22, -23, -24));

    // Reset with a pending window
    step(1'b1, 25, 1'b0, 1'b0, 1'b0);
    chk1("pend_tvalid", tv_a, 1'b1);
    step(1'b1, 26, 1'b1, 1'b0, 1'b1);
    chk1("rst2_tvalid", tv_a, 1'b0);
    chk("rst2_wi", wi_a, 60'd0);
    chk("rst2_wq", wq_a, 60'd0);
    chk1("rst2_tvalid_b", tv_b, 1'b0);
    for (int a = 30; a <= 34; a++) begin
      step(1'b1, a, 1'b0, 1'b0, 1'b1);
      if (a == 33) chk1("rst2_early", tv_a, 1'b0);
    end
    chk("rst2_refill", wi_a, pk(30, 31, 32, 33, 34));

    // Mixed valid / ready pattern, model-checked every cycle
    for (int i = 0; i < 40; i++)
      step((i % 4) != 1, 40 + i, 1'b0, 1'b0, (i % 3) != 0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpx_window.md
CPX_WINDOW -- requirements
Module: cpx_window

Interface
REQ-001 SHALL have parameter i_bits, default 12, in-phase sample width (signed).
REQ-002 SHALL have parameter q_bits, default 12, quadrature sample width (signed).
REQ-003 SHALL have parameter length, default 5, window depth in complex samples (>=2).
REQ-004 SHALL have parameter stride, default 1, accepted samples between successive windows once streaming (1..length).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port clear  input  1  synchronous restart of window fill; storage not zeroed.
REQ-008 SHALL have port m_axis_data_tvalid  input  1  upstream sample valid.
REQ-009 SHALL have port s_axis_data_tready  output  1  sample accepted this cycle when high with m_axis_data_tvalid.
REQ-010 SHALL have port xi  input  i_bits  signed in-phase sample.
REQ-011 SHALL have port xq  input  q_bits  signed quadrature sample.
REQ-012 SHALL have port m_axis_window_tready  input  1  downstream (dot_prod) ready for a window.
REQ-013 SHALL have port s_axis_tvalid  output  1  window valid (registered).
REQ-014 SHALL have port wi  output  i_bits*length  packed in-phase window; element k at bits [i_bits*k+i_bits-1 : i_bits*k].
REQ-015 SHALL have port wq  output  q_bits*length  packed quadrature window, same packing.

Function
REQ-016 SHALL drive s_axis_data_tready = !reset & !clear & (!s_axis_tvalid | m_axis_window_tready), combinationally.
REQ-017 SHALL, on accept, shift storage element k <- k+1 and load element length-1 with (xi,xq); element 0 oldest, length-1 newest.
REQ-018 SHALL implement states FILL and STREAM; FILL counts accepted samples 0..length-1.
REQ-019 SHALL, in FILL, on the accept that completes length samples, emit a window and enter STREAM with hop count 0.
REQ-020 SHALL, in STREAM, increment hop count per accept and emit on the accept where hop count reaches stride-1, then reset hop count to 0.
REQ-021 SHALL emit by loading wi/wq with post-shift storage and setting s_axis_tvalid on the cycle after the completing accept (latency 1 clock).
REQ-022 SHALL hold wi, wq, s_axis_tvalid stable while s_axis_tvalid=1 and m_axis_window_tready=0.
REQ-023 SHALL clear s_axis_tvalid after a transfer (s_axis_tvalid & m_axis_window_tready) unless an emit occurs the same cycle, in which case it stays 1 with new data.
REQ-024 SHALL ignore samples while s_axis_data_tready=0; no sample loss or duplication under any backpressure pattern.
REQ-025 SHALL, on clear, enter FILL, zero fill and hop counts, drop s_axis_tvalid; any pending window is discarded.
REQ-026 SHALL treat samples as opaque bit fields; no arithmetic, no width change.

Reset
REQ-027 SHALL, on reset, enter FILL, zero counts, storage, wi, wq, and drive s_axis_tvalid=0, s_axis_data_tready=0.
REQ-028 SHALL give reset priority over clear and over any simultaneous accept or transfer.
REQ-029 SHALL resume normal operation on the first cycle reset is low, requiring length fresh samples before the first window.

Structure
REQ-030 SHALL take state encoding (FILL, STREAM) and counter-width helper from the shared package caf_pkg.
REQ-031 SHALL place storage in one sub-module cpx_window_shift (parameterised complex shift register with shift enable and packed outputs).

Verification
REQ-032 SHALL cover fill: length=5, stride=1, samples xi=1..5 xq=-1..-5, tready=1 -> one window at cycle after 5th accept, wi elements {1,2,3,4,5}, wq {-1..-5}.
REQ-033 SHALL cover sliding: continue with xi=6,7 -> windows {2..6}, {3..7} on consecutive cycles.
REQ-034 SHALL cover stride: stride=2, xi=1..9 continuous -> windows {1..5}, {3..7}, {5..9} only.
REQ-035 SHALL cover backpressure: window tready low 4 cycles after first window -> s_axis_data_tready=0, wi held {1..5}; on release next window {2..6}, no sample lost.
REQ-036 SHALL cover clear mid-stream: clear after 7 samples -> s_axis_tvalid=0, next window only after 5 new samples, containing only those.
REQ-037 SHALL cover reset mid-stream with valid window pending -> all outputs 0 next cycle, refill required.
